// File: rtl/req_ack_bfm.sv
// req_ack_bfm: command FIFO feeding a four-phase req/ack initiator over N_CHAN channels.
// Ports: cmd_* push side, req/ack/data handshake side, done_* completion, level, xfer_count.
module req_ack_bfm #(
  parameter int DATA_WIDTH = 8,
  parameter int N_CHAN = 4,
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 64,
  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CW-1:0]         cmd_chan,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic [N_CHAN-1:0]     req,
  input  logic [N_CHAN-1:0]     ack,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  done_valid,
  output logic [CW-1:0]         done_chan,
  output logic                  done_timeout,
  output logic [LW-1:0]         level,
  output logic [31:0]           xfer_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  logic [CW-1:0]         mem_chan [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  state_t                state;
  logic [N_CHAN-1:0]     sel;
  logic [CW-1:0]         cur_chan;
  logic [TW-1:0]         cnt;

  logic                  push;
  logic                  pop;
  logic                  hit;
  logic                  expire;
  logic                  head_ok;
  logic [CW-1:0]         head_chan;
  logic [DATA_WIDTH-1:0] head_data;

  // ready depends only on registered occupancy: a same-cycle pop
  // never opens a slot for a push when full
  assign cmd_ready = (level != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (level != '0);
  assign head_chan = mem_chan[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign head_ok   = (32'(head_chan) < 32'(N_CHAN));
  // sel remembers the active channel after req drops in REL
  assign hit       = |(ack & sel);
  assign expire    = (TIMEOUT != 0) && (cnt == TLIM);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_chan[wr_ptr] <= cmd_chan;
      mem_data[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req          <= '0;
      sel          <= '0;
      cur_chan     <= '0;
      cnt          <= '0;
      data         <= '0;
      done_valid   <= 1'b0;
      done_chan    <= '0;
      done_timeout <= 1'b0;
      xfer_count   <= '0;
    end else begin
      done_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            cur_chan <= head_chan;
            if (head_ok) begin
              req   <= N_CHAN'(1) << head_chan;
              sel   <= N_CHAN'(1) << head_chan;
              data  <= head_data;
              cnt   <= '0;
              state <= REQ;
            end else begin
              done_valid   <= 1'b1;
              done_chan    <= head_chan;
              done_timeout <= 1'b1;
            end
          end
        end
        REQ: begin
          if (hit) begin
            req   <= '0;
            cnt   <= '0;
            state <= REL;
          end else if (expire) begin
            req          <= '0;
            done_valid   <= 1'b1;
            done_chan    <= cur_chan;
            done_timeout <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL: begin
          if (!hit) begin
            done_valid   <= 1'b1;
            done_chan    <= cur_chan;
            done_timeout <= 1'b0;
            xfer_count   <= xfer_count + 32'd1;
            state        <= IDLE;
          end else if (expire) begin
            done_valid   <= 1'b1;
            done_chan    <= cur_chan;
            done_timeout <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_ack_bfm.sv
// tb_req_ack_bfm: randomized + directed bench with scoreboard for req_ack_bfm.
// A second small instance covers the out-of-range channel case.
module tb_req_ack_bfm;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int DP = 8;
  localparam int TO = 64;

  typedef enum int {LOOP, ZERO, ONE} mode_t;
  typedef struct {
    int chan;
    int data;
    bit tmo;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_chan = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [NC-1:0] req;
  logic [NC-1:0] ack = '0;
  logic [DW-1:0] data;
  logic          done_valid;
  logic [1:0]    done_chan;
  logic          done_timeout;
  logic [3:0]    level;
  logic [31:0]   xfer_count;

  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [1:0]    s_chan = '0;
  logic [7:0]    s_cdata = '0;
  logic [2:0]    s_req;
  logic [2:0]    s_ack = '0;
  logic [7:0]    s_data;
  logic          s_done;
  logic [1:0]    s_dchan;
  logic          s_dtmo;
  logic [2:0]    s_level;
  logic [31:0]   s_xfer;

  mode_t mode [NC];
  exp_t  sb [$];
  int    errors = 0;
  int    checks = 0;
  int    exp_xfer = 0;

  always #5 clk = ~clk;

  req_ack_bfm #(
    .DATA_WIDTH(DW), .N_CHAN(NC), .DEPTH(DP), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_data(cmd_data),
    .req(req), .ack(ack), .data(data),
    .done_valid(done_valid), .done_chan(done_chan),
    .done_timeout(done_timeout), .level(level),
    .xfer_count(xfer_count)
  );

  req_ack_bfm #(
    .DATA_WIDTH(8), .N_CHAN(3), .DEPTH(4), .TIMEOUT(8)
  ) u_small (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_chan(s_chan), .cmd_data(s_cdata),
    .req(s_req), .ack(s_ack), .data(s_data),
    .done_valid(s_done), .done_chan(s_dchan),
    .done_timeout(s_dtmo), .level(s_level),
    .xfer_count(s_xfer)
  );

  // DUT-side responder: loopback register, stuck-low or stuck-high
  always @(posedge clk) begin
    for (int c = 0; c < NC; c++)
      ack[c] <= (mode[c] == LOOP) ? req[c] : (mode[c] == ONE);
    s_ack <= s_req;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got chan %0d expected no done",
                 done_chan);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!e.tmo)
          exp_xfer++;
        check("done_chan", done_chan, e.chan);
        check("done_timeout", done_timeout, e.tmo);
        check("done_data", data, e.data);
        check("xfer_count", xfer_count, exp_xfer);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int d, input bit tmo);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_wait: got ready 0 expected 1");
    end else begin
      cmd_valid = 1'b1;
      cmd_chan  = 2'(ch);
      cmd_data  = 8'(d);
      e.chan = ch;
      e.data = d & 8'hFF;
      e.tmo  = tmo;
      sb.push_back(e);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first;
    int cnt;
    int dat;
    int dcnt;
    logic r64;
    logic r65;

    for (int c = 0; c < NC; c++)
      mode[c] = LOOP;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_req", req, 0);
    check("rst_data", data, 0);
    check("rst_done", done_valid, 0);
    check("rst_dchan", done_chan, 0);
    check("rst_dtmo", done_timeout, 0);
    check("rst_level", level, 0);
    check("rst_xfer", xfer_count, 0);

    // single loopback transaction, timing from the pop edge
    push(2, 8'hA5, 1'b0);
    first = -1; cnt = 0; dat = -1; dcnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (req == 4'b0100) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (done_valid) begin
        dcnt++;
        dat = i;
      end
      if (i == 1) check("t1_data", data, 8'hA5);
    end
    check("t1_req_first", first, 1);
    check("t1_req_len", cnt, 2);
    check("t1_done_at", dat, 5);
    check("t1_done_cnt", dcnt, 1);
    check("t1_xfer", xfer_count, 1);
    check("t1_dchan_hold", done_chan, 2);
    drain(50);

    // out-of-range channel on a 3-channel build
    @(negedge clk);
    s_valid = 1'b1; s_chan = 2'd3; s_cdata = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    s_cdata = 8'h3D;
    @(posedge clk);
    #1 s_valid = 1'b0;
    check("bad_done1", s_done, 1);
    check("bad_tmo", s_dtmo, 1);
    check("bad_chan", s_dchan, 3);
    check("bad_req", s_req, 0);
    tick();
    check("bad_done2", s_done, 1);
    check("bad_data", s_data, 0);
    tick();
    check("bad_done_end", s_done, 0);
    check("bad_xfer", s_xfer, 0);
    @(negedge clk);
    s_valid = 1'b1; s_chan = 2'd1; s_cdata = 8'h5A;
    @(posedge clk);
    #1 s_valid = 1'b0;
    dat = -1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (s_done) begin
        dat = i;
        check("small_tmo", s_dtmo, 0);
      end
    end
    check("small_done_at", dat, 5);
    check("small_xfer", s_xfer, 1);
    check("small_data", s_data, 8'h5A);

    // REQ-phase timeout on channel 1
    mode[1] = ZERO;
    push(1, 8'h3C, 1'b1);
    dat = -1; r64 = 1'bx; r65 = 1'bx;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (done_valid && dat < 0) dat = i;
      if (i == 64) r64 = req[1];
      if (i == 65) r65 = req[1];
    end
    check("to_done_at", dat, 65);
    check("to_req_before", r64, 1);
    check("to_req_after", r65, 0);
    check("to_xfer", xfer_count, 1);
    mode[1] = LOOP;
    push(0, 8'h81, 1'b0);
    drain(50);
    check("to_next_xfer", xfer_count, 2);

    // stuck-high ack on channel 3: REL-phase timeout
    mode[3] = ONE;
    repeat (2) tick();
    push(3, 8'h77, 1'b1);
    cnt = 0; dat = -1;
    for (int i = 1; i <= 72; i++) begin
      tick();
      if (req[3]) cnt++;
      if (done_valid && dat < 0) dat = i;
    end
    check("stk_req_len", cnt, 1);
    check("stk_done_at", dat, 66);
    drain(50);
    mode[3] = LOOP;
    repeat (2) tick();

    // fill the FIFO behind a stalled handshake
    mode[0] = ZERO;
    for (int k = 0; k < 9; k++)
      push(0, 8'h10 + k, 1'b0);
    check("full_level", level, 8);
    check("full_ready", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_chan = 2'd0; cmd_data = 8'hEE;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("full_refused", level, 8);
    mode[0] = LOOP;
    drain(200);

    // asynchronous reset mid-transaction
    mode[0] = ZERO;
    for (int k = 0; k < 4; k++)
      push(0, 8'h60 + k, 1'b1);
    repeat (2) tick();
    check("rr_req_pre", req, 4'b0001);
    check("rr_level_pre", level, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rr_req", req, 0);
    check("rr_level", level, 0);
    check("rr_xfer", xfer_count, 0);
    sb.delete();
    exp_xfer = 0;
    mode[0] = LOOP;
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_valid) dcnt++;
    end
    check("rr_no_done", dcnt, 0);

    // randomized traffic: 0,1 loopback, 2 stuck low, 3 stuck high
    mode[2] = ZERO;
    mode[3] = ONE;
    repeat (2) tick();
    for (int k = 0; k < 20; k++) begin
      int ch;
      ch = $urandom_range(0, 3);
      push(ch, $urandom_range(0, 255), ch >= 2);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
